// File: rtl/cirno_pkg.sv
// cirno_pkg: shared types and constants for the 8-bit Cirno core (control unit,
// ALU and register file).
// Contents: FSM state enum, opcode enum, ALU function codes, decode result and
// control-bundle structs, instruction field-slice positions, PC_W default.
package cirno_pkg;

  localparam int unsigned PC_W_DEF  = 8;
  localparam int unsigned INSTR_W   = 8;
  localparam int unsigned REG_SEL_W = 2;
  localparam int unsigned IMM_W     = 6;
  localparam int unsigned ALU_OP_W  = 3;
  localparam int unsigned RETIRE_W  = 16;

  // Instruction field slices
  localparam int unsigned OP_HI     = 7;
  localparam int unsigned OP_LO     = 4;
  localparam int unsigned LI_HI     = 7;
  localparam int unsigned LI_LO     = 6;
  localparam int unsigned LI_SEL_HI = 5;
  localparam int unsigned LI_SEL_LO = 4;
  localparam int unsigned R1_HI     = 3;
  localparam int unsigned R1_LO     = 2;
  localparam int unsigned R2_HI     = 1;
  localparam int unsigned R2_LO     = 0;
  localparam int unsigned IMM_HI    = 5;
  localparam int unsigned IMM_LO    = 0;

  // ir[7:6] prefixes that claim the load-immediate forms
  localparam logic [1:0] LI_LIL = 2'b10;
  localparam logic [1:0] LI_LIH = 2'b11;

  typedef enum logic [2:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_READ, ST_EXEC, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    OPC_NOP  = 4'd0,
    OPC_MOV  = 4'd1,
    OPC_ADD  = 4'd2,
    OPC_SUB  = 4'd3,
    OPC_AND  = 4'd4,
    OPC_OR   = 4'd5,
    OPC_XOR  = 4'd6,
    OPC_HALT = 4'd7
  } opcode_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_MOV, CLS_ALU, CLS_HALT, CLS_LIL, CLS_LIH
  } op_class_e;

  typedef struct packed {
    logic [REG_SEL_W-1:0] r1;
    logic [REG_SEL_W-1:0] r2;
    logic [IMM_W-1:0]     imm;
    op_class_e            op_class;
    alu_op_e              alu_op;
  } dec_t;

  typedef struct packed {
    logic fetch_req;
    logic readx_en;
    logic ready_en;
    logic r_en;
    logic w_en;
    logic hi_en;
    logic lo_en;
    logic swap_en;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/cirno_decode.sv
// cirno_decode: combinational instruction decoder for the Cirno core.
// Ports: ir    - instruction word to decode
//        dec_c - register selects, immediate, op class and ALU function
module cirno_decode
  import cirno_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output dec_t               dec_c
);

  // ir[7:6] of 10/11 overrides the opcode field with the load-immediate forms
  always_comb begin
    dec_c.r1       = ir[R1_HI:R1_LO];
    dec_c.r2       = ir[R2_HI:R2_LO];
    dec_c.imm      = ir[IMM_HI:IMM_LO];
    dec_c.op_class = CLS_NOP;
    dec_c.alu_op   = ALU_ADD;
    if (ir[LI_HI:LI_LO] == LI_LIL) begin
      dec_c.r1       = ir[LI_SEL_HI:LI_SEL_LO];
      dec_c.op_class = CLS_LIL;
    end else if (ir[LI_HI:LI_LO] == LI_LIH) begin
      dec_c.r1       = ir[LI_SEL_HI:LI_SEL_LO];
      dec_c.op_class = CLS_LIH;
    end else begin
      case (ir[OP_HI:OP_LO])
        OPC_MOV:  dec_c.op_class = CLS_MOV;
        OPC_ADD:  begin dec_c.op_class = CLS_ALU; dec_c.alu_op = ALU_ADD; end
        OPC_SUB:  begin dec_c.op_class = CLS_ALU; dec_c.alu_op = ALU_SUB; end
        OPC_AND:  begin dec_c.op_class = CLS_ALU; dec_c.alu_op = ALU_AND; end
        OPC_OR:   begin dec_c.op_class = CLS_ALU; dec_c.alu_op = ALU_OR;  end
        OPC_XOR:  begin dec_c.op_class = CLS_ALU; dec_c.alu_op = ALU_XOR; end
        OPC_HALT: dec_c.op_class = CLS_HALT;
        default:  dec_c.op_class = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/cirno_control_unit.sv
// cirno_control_unit: fetch/decode/sequence FSM of the 8-bit Cirno core.
// Ports: clk, rst_n (async active-low)
//        fetch_req/pc/instr_valid/instr - instruction fetch handshake
//        r1, r2, immediate              - register-file operand fields
//        reg_*_en                       - register-file control pulses
//        alu_op                         - ALU function for the EXEC write-back
//        halted                         - core stopped until reset
//        retired                        - completed-instruction count, only
//                                         when CIRNO_RETIRE_CNT_EN is defined
// All outputs are registered: each register is loaded with the value that
// belongs to the state being entered, so outputs line up with the state.
module cirno_control_unit
  import cirno_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 fetch_req,
  output logic [PC_W-1:0]      pc,
  input  logic                 instr_valid,
  input  logic [INSTR_W-1:0]   instr,
  output logic [REG_SEL_W-1:0] r1,
  output logic [REG_SEL_W-1:0] r2,
  output logic [IMM_W-1:0]     immediate,
  output logic                 reg_readx_en,
  output logic                 reg_ready_en,
  output logic                 reg_r_en,
  output logic                 reg_w_en,
  output logic                 reg_hi_en,
  output logic                 reg_lo_en,
  output logic                 reg_swap_en,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 halted
`ifdef CIRNO_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0]  retired
`endif
);

  state_e             state, state_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic               xfer_c;
  dec_t               dec_c;
  ctrl_t              ctrl_nxt, ctrl_q;

  // Decode the word the ir will hold next so DECODE-cycle fields are ready
  assign xfer_c = (state == ST_FETCH) && instr_valid;
  assign ir_nxt = xfer_c ? instr : ir;

  cirno_decode u_decode (
    .ir    (ir_nxt),
    .dec_c (dec_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= state_nxt;
  end

  // Next state and the control bundle for the state being entered
  always_comb begin
    state_nxt = state;
    ctrl_nxt  = '0;
    case (state)
      ST_RESET:  state_nxt = ST_FETCH;
      ST_FETCH:  if (xfer_c) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (dec_c.op_class)
          CLS_HALT: state_nxt = ST_HALT;
          CLS_ALU:  state_nxt = ST_READ;
          default:  state_nxt = ST_FETCH;
        endcase
      end
      ST_READ:   state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_RESET;
    endcase
    case (state_nxt)
      ST_FETCH:  ctrl_nxt.fetch_req = 1'b1;
      ST_DECODE: begin
        ctrl_nxt.lo_en   = (dec_c.op_class == CLS_LIL);
        ctrl_nxt.hi_en   = (dec_c.op_class == CLS_LIH);
        ctrl_nxt.swap_en = (dec_c.op_class == CLS_MOV);
      end
      ST_READ: begin
        ctrl_nxt.r_en     = 1'b1;
        ctrl_nxt.readx_en = 1'b1;
        ctrl_nxt.ready_en = 1'b1;
      end
      ST_EXEC:   ctrl_nxt.w_en   = 1'b1;
      ST_HALT:   ctrl_nxt.halted = 1'b1;
      default:   ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      ir        <= '0;
      ctrl_q    <= '0;
      r1        <= '0;
      r2        <= '0;
      immediate <= '0;
      alu_op    <= '0;
    end else begin
      if (xfer_c) begin
        pc <= pc + PC_W'(1);
        ir <= ir_nxt;
      end
      ctrl_q    <= ctrl_nxt;
      r1        <= dec_c.r1;
      r2        <= dec_c.r2;
      immediate <= dec_c.imm;
      alu_op    <= dec_c.alu_op;
    end
  end

  assign fetch_req    = ctrl_q.fetch_req;
  assign reg_readx_en = ctrl_q.readx_en;
  assign reg_ready_en = ctrl_q.ready_en;
  assign reg_r_en     = ctrl_q.r_en;
  assign reg_w_en     = ctrl_q.w_en;
  assign reg_hi_en    = ctrl_q.hi_en;
  assign reg_lo_en    = ctrl_q.lo_en;
  assign reg_swap_en  = ctrl_q.swap_en;
  assign halted       = ctrl_q.halted;

`ifdef CIRNO_RETIRE_CNT_EN
  logic retire_c;

  // An instruction retires on leaving EXEC, or DECODE when it needs no ALU
  assign retire_c = (state == ST_EXEC) ||
                    ((state == ST_DECODE) && (dec_c.op_class != CLS_ALU) &&
                     (dec_c.op_class != CLS_HALT));

  // Saturating retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             retired <= '0;
    else if (retire_c && (retired != '1))   retired <= retired + RETIRE_W'(1);
  end
`endif

endmodule

// File: tb/tb_cirno_control_unit.sv
// tb_cirno_control_unit: self-checking bench for cirno_control_unit.
// A per-instruction cycle schedule predicts every output each cycle; an
// architectural register model is compared with a bench register file that
// obeys the DUT's enables. Define CIRNO_RETIRE_CNT_EN to also check retired.
module tb_cirno_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       fetch_req;
  logic [7:0] pc;
  logic [1:0] r1, r2;
  logic [5:0] immediate;
  logic       reg_readx_en, reg_ready_en, reg_r_en, reg_w_en;
  logic       reg_hi_en, reg_lo_en, reg_swap_en, halted;
  logic [2:0] alu_op;
`ifdef CIRNO_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  cirno_control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .r1           (r1),
    .r2           (r2),
    .immediate    (immediate),
    .reg_readx_en (reg_readx_en),
    .reg_ready_en (reg_ready_en),
    .reg_r_en     (reg_r_en),
    .reg_w_en     (reg_w_en),
    .reg_hi_en    (reg_hi_en),
    .reg_lo_en    (reg_lo_en),
    .reg_swap_en  (reg_swap_en),
    .alu_op       (alu_op),
    .halted       (halted)
`ifdef CIRNO_RETIRE_CNT_EN
    ,
    .retired      (retired)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One expected cycle of DUT behaviour
  typedef struct packed {
    bit       fetch, lo, hi, swap, rd, wr, halt;
    bit       chk, chk_r2, chk_aop, last;
    bit [1:0] r1, r2;
    bit [5:0] imm;
    bit [2:0] aop;
    bit [7:0] ins;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] m_pc = 8'h00;
  bit         m_halted = 1'b0;
  bit         after_rst = 1'b0;
  bit         commit_now = 1'b0;
  logic [7:0] cm_ins = 8'h00;
  logic [15:0] m_retired = 16'h0;
  logic [7:0] arf [4];
  logic [7:0] brf [4];
  logic [7:0] bx = 8'h00, by = 8'h00;

  initial begin
    for (int k = 0; k < 4; k++) begin arf[k] = 8'h00; brf[k] = 8'h00; end
  end

  // Expected cycles following the fetch of instruction i
  task automatic schedule(input logic [7:0] i);
    rec_t d, r, w;
    d = '0;
    d.chk = 1'b1; d.ins = i; d.imm = i[5:0]; d.r2 = i[1:0];
    d.r1 = i[7] ? i[5:4] : i[3:2];
    d.chk_r2 = !i[7];
    if (i[7]) begin
      if (i[6]) d.hi = 1'b1; else d.lo = 1'b1;
      d.last = 1'b1;
      exp_q.push_back(d);
    end else begin
      case (i[6:4])
        3'd0: begin d.last = 1'b1; exp_q.push_back(d); end
        3'd1: begin d.swap = 1'b1; d.last = 1'b1; exp_q.push_back(d); end
        3'd7: begin exp_q.push_back(d); m_halted = 1'b1; end
        default: begin
          exp_q.push_back(d);
          r = d; r.rd = 1'b1; exp_q.push_back(r);
          w = d; w.wr = 1'b1; w.chk_aop = 1'b1; w.aop = 3'(i[6:4] - 3'd2); w.last = 1'b1;
          exp_q.push_back(w);
        end
      endcase
    end
  endtask

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      default: return 8'hxx;
    endcase
  endfunction

  // Architectural commit and bench register file driven by the DUT enables
  always @(posedge clk) begin
    if (!rst_n) m_retired = 16'h0;
    else if (commit_now) begin
      if (cm_ins[7]) begin
        if (cm_ins[6]) arf[cm_ins[5:4]][7:4] = cm_ins[3:0];
        else           arf[cm_ins[5:4]][3:0] = cm_ins[3:0];
      end else begin
        case (cm_ins[6:4])
          3'd1: arf[cm_ins[3:2]] = arf[cm_ins[1:0]];
          3'd2: arf[cm_ins[3:2]] = arf[cm_ins[3:2]] + arf[cm_ins[1:0]];
          3'd3: arf[cm_ins[3:2]] = arf[cm_ins[3:2]] - arf[cm_ins[1:0]];
          3'd4: arf[cm_ins[3:2]] = arf[cm_ins[3:2]] & arf[cm_ins[1:0]];
          3'd5: arf[cm_ins[3:2]] = arf[cm_ins[3:2]] | arf[cm_ins[1:0]];
          3'd6: arf[cm_ins[3:2]] = arf[cm_ins[3:2]] ^ arf[cm_ins[1:0]];
          default: ;
        endcase
      end
      if (m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
    end
    if (reg_r_en) begin bx = brf[r1]; by = brf[r2]; end
    if (reg_w_en) brf[r1] = alu(alu_op, bx, by);
    if (reg_lo_en) brf[r1][3:0] = immediate[3:0];
    if (reg_hi_en) brf[r1][7:4] = immediate[3:0];
    if (reg_swap_en) brf[r1] = brf[r2];
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    rec_t e;
    bit   zero_rec;
    e = '0;
    zero_rec = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_pc = 8'h00; m_halted = 1'b0; after_rst = 1'b1; commit_now = 1'b0;
      zero_rec = 1'b1;
    end else if (after_rst) begin
      after_rst = 1'b0; commit_now = 1'b0;
      zero_rec = 1'b1;
    end else if (exp_q.size() > 0) e = exp_q.pop_front();
    else if (m_halted) e.halt = 1'b1;
    else e.fetch = 1'b1;
    if (zero_rec) begin e.chk = 1'b1; e.chk_r2 = 1'b1; e.chk_aop = 1'b1; end
    check("ctrl", {fetch_req, reg_lo_en, reg_hi_en, reg_swap_en, reg_r_en, reg_readx_en,
                   reg_ready_en, reg_w_en, halted},
                  {e.fetch, e.lo, e.hi, e.swap, e.rd, e.rd, e.rd, e.wr, e.halt});
    check("pc", pc, m_pc);
    if (e.chk)     check("r1_imm", {r1, immediate}, {e.r1, e.imm});
    if (e.chk_r2)  check("r2", r2, e.r2);
    if (e.chk_aop) check("alu_op", alu_op, e.aop);
    check("regfile", {brf[3], brf[2], brf[1], brf[0]}, {arf[3], arf[2], arf[1], arf[0]});
`ifdef CIRNO_RETIRE_CNT_EN
    check("retired", retired, zero_rec ? 16'h0 : m_retired);
`endif
    if (!zero_rec) begin
      commit_now = e.last;
      cm_ins = e.ins;
      if (e.fetch && instr_valid) begin
        m_pc = m_pc + 8'd1;
        schedule(instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) for fetch_req, stall, then hand over one instruction
  task automatic fetch(input logic [7:0] i, input int stall);
    int n;
    n = 0;
    while (!fetch_req && n < 20) begin
      instr_valid = 1'($urandom);
      instr = 8'($urandom);
      tick();
      n++;
    end
    instr_valid = 1'b0;
    check("fetch_wait", fetch_req, 1);
    repeat (stall) tick();
    instr_valid = 1'b1;
    instr = i;
    tick();
    instr_valid = 1'b0;
    instr = 8'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         sel;
    logic [7:0] ins;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_fetch_req", fetch_req, 0);
    check("rst_pc", pc, 0);
    rst_n = 1'b1;
    check("reset_cycle_fetch_req", fetch_req, 0);
    tick();
    check("first_fetch_req", fetch_req, 1);

    // LIL r2,5
    fetch(8'hA5, 0);
    check("lil_lo_en", reg_lo_en, 1);
    check("lil_r1", r1, 2);
    check("lil_imm", immediate[3:0], 5);
    check("lil_pc", pc, 1);
    tick();
    check("lil_pulse_end", reg_lo_en, 0);

    // r1=0xF0, r2=0x20, then ADD r1,r2
    fetch(8'h90, 0); fetch(8'hDF, 0); fetch(8'hA0, 0); fetch(8'hE2, 0);
    fetch(8'h26, 0);
    check("add_decode_idle", {reg_r_en, reg_w_en}, 0);
    tick();
    check("add_read", {reg_r_en, reg_readx_en, reg_ready_en, reg_w_en}, 4'b1110);
    tick();
    check("add_exec", {reg_r_en, reg_w_en}, 2'b01);
    check("add_alu_op", alu_op, 0);
    tick();
    check("add_result", brf[1], 8'h10);
    check("add_w_pulse_end", reg_w_en, 0);

    // Fetch stall of 3 cycles
    instr_valid = 1'b0;
    repeat (3) begin
      tick();
      check("stall_fetch_req", fetch_req, 1);
      check("stall_pc", pc, 6);
      check("stall_enables", {reg_r_en, reg_w_en, reg_hi_en, reg_lo_en, reg_swap_en}, 0);
    end
    fetch(8'h00, 0);
    check("stall_nop_pc", pc, 7);

    // Reset during EXEC of SUB r3,r3 must suppress the write
    fetch(8'hB7, 0); fetch(8'h3F, 0);
    tick(); tick();
    check("exec_w_en", reg_w_en, 1);
    rst_n = 1'b0;
    #1;
    check("async_w_en_drop", reg_w_en, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("write_suppressed", brf[3], 8'h07);
`ifdef CIRNO_RETIRE_CNT_EN
    check("retired_after_rst", retired, 0);
`endif

    // HALT holds until reset
    fetch(8'h70, 0);
    check("halt_decode", halted, 0);
    tick();
    instr_valid = 1'b1;
    instr = 8'h00;
    repeat (5) begin
      check("halted", halted, 1);
      check("halt_no_fetch", fetch_req, 0);
      tick();
    end
    instr_valid = 1'b0;
    do_reset();
    check("halt_cleared", halted, 0);

    // PC wrap
    for (int k = 0; k < 255; k++) fetch({4'h0, 4'($urandom)}, 0);
    check("pc_ff", pc, 8'hFF);
    fetch(8'h00, 0);
    check("pc_wrap", pc, 8'h00);

    // Randomised instruction stream with stalls and occasional resets
    for (int k = 0; k < 250; k++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 30)      ins = {1'b1, 1'($urandom), 6'($urandom)};
      else if (sel < 45) ins = {4'h1, 4'($urandom)};
      else if (sel < 52) ins = {4'h0, 4'($urandom)};
      else if (sel < 96) ins = {1'b0, 3'($urandom_range(2, 6)), 4'($urandom)};
      else               ins = {4'h7, 4'($urandom)};
      fetch(ins, int'($urandom_range(0, 3)));
      if (ins[7:4] == 4'h7) begin
        repeat ($urandom_range(1, 4)) begin
          instr_valid = 1'($urandom);
          instr = 8'($urandom);
          tick();
        end
        instr_valid = 1'b0;
        do_reset();
      end else if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(0, 2)) tick();
        do_reset();
      end
    end
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
